// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - iterative unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q;
  logic [WIDTH:0]   a_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic [WIDTH:0]   a_sh_d;
  logic [WIDTH:0]   diff_d;
  logic [WIDTH:0]   a_d;
  logic [WIDTH-1:0] q_d;
  logic [CNT_W-1:0] cnt_d;

  // One restoring step: trial-subtract the divisor from the shifted partial remainder.
  always_comb begin
    a_sh_d = (a_q << 1) | {{WIDTH{1'b0}}, q_q[WIDTH-1]};
    diff_d = a_sh_d - {1'b0, d_q};
    a_d    = diff_d[WIDTH] ? a_sh_d : diff_d;
    q_d    = {q_q[WIDTH-2:0], ~diff_d[WIDTH]};
    cnt_d  = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            d_q    <= divisor;
            q_q    <= dividend;
            a_q    <= '0;
            cnt_q  <= CNT_W'(WIDTH);
            busy_q <= 1'b1;
            if (divisor == '0) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          a_q   <= a_d;
          q_q   <= q_d;
          cnt_q <= cnt_d;
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            quotient_q  <= q_d;
            remainder_q <= a_d[WIDTH-1:0];
            dbz_q       <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  bit           hold_en = 1'b0;
  bit           have_last = 1'b0;
  logic [W-1:0] last_q, last_r;
  logic         last_z;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t res;
    if (b == 0) begin
      res.q = {W{1'b1}};
      res.r = a;
      res.z = 1'b1;
    end else begin
      res.q = a / b;
      res.r = a % b;
      res.z = 1'b0;
    end
    return res;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return {W{1'b1}};
      2:       return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  // Outputs may only move in a done cycle.
  always @(negedge clk) begin
    if (hold_en) begin
      if (done) begin
        last_q    = quotient;
        last_r    = remainder;
        last_z    = div_by_zero;
        have_last = 1'b1;
      end else if (have_last) begin
        check("hold", {31'd0, quotient, remainder, div_by_zero}, {31'd0, last_q, last_r, last_z});
      end
    end
  end

  // Called at a negedge with the block IDLE or DONE; returns at the done negedge.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input res_t exp, input string tag);
    int k;
    int lat;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = 1;
    check({tag, " busy"}, 64'(busy), 64'd1);
    while (!done && k < 40) begin
      start    = 1'($urandom_range(0, 1));
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    lat = (b == 0) ? 1 : W + 1;
    check({tag, " latency"}, 64'(k), 64'(lat));
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " result"}, {31'd0, quotient, remainder, div_by_zero}, {31'd0, exp.q, exp.r, exp.z});
  endtask

  vec_t vecs[10];
  logic [W-1:0] bb_a[5];
  logic [W-1:0] bb_b[5];

  initial begin
    vecs[0] = '{16'd100,  16'd7,    16'd14,   16'd2, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'd0, 1'b0};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 16'd1,    16'd0, 1'b0};
    vecs[3] = '{16'd3,    16'd10,   16'd0,    16'd3, 1'b0};
    vecs[4] = '{16'd5,    16'd0,    16'hFFFF, 16'd5, 1'b1};
    vecs[5] = '{16'd1000, 16'd3,    16'd333,  16'd1, 1'b0};
    vecs[6] = '{16'd0,    16'd5,    16'd0,    16'd0, 1'b0};
    vecs[7] = '{16'd0,    16'd0,    16'hFFFF, 16'd0, 1'b1};
    vecs[8] = '{16'd1,    16'hFFFF, 16'd0,    16'd1, 1'b0};
    vecs[9] = '{16'hABCD, 16'h0100, 16'h00AB, 16'h00CD, 1'b0};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset quotient", 64'(quotient), 64'd0);
    check("reset remainder", 64'(remainder), 64'd0);
    check("reset dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      res_t e;
      e.q = vecs[i].q;
      e.r = vecs[i].r;
      e.z = vecs[i].z;
      do_div(vecs[i].a, vecs[i].b, e, $sformatf("vec%0d", i));
    end

    // Back-to-back: start held high, operands scrambled during RUN.
    for (int i = 0; i < 5; i++) begin
      bb_a[i] = W'($urandom);
      bb_b[i] = W'($urandom_range(1, 16'hFFFF));
    end
    bb_b[2] = W'(3);
    begin
      int idx = 0;
      int since = 0;
      int k = 0;
      dividend = bb_a[0];
      divisor  = bb_b[0];
      start    = 1'b1;
      while (idx < 5 && k < 200) begin
        @(negedge clk);
        k++;
        since++;
        if (done) begin
          res_t e;
          e = ref_div(bb_a[idx], bb_b[idx]);
          check($sformatf("b2b%0d interval", idx), 64'(since), 64'(W + 1));
          check($sformatf("b2b%0d result", idx), {31'd0, quotient, remainder, div_by_zero},
                {31'd0, e.q, e.r, e.z});
          since = 0;
          idx++;
          if (idx < 5) begin
            dividend = bb_a[idx];
            divisor  = bb_b[idx];
          end else begin
            start = 1'b0;
          end
        end else begin
          dividend = W'($urandom);
          divisor  = W'($urandom);
        end
      end
      start = 1'b0;
      check("b2b completed", 64'(idx), 64'd5);
    end
    @(negedge clk);

    // Asynchronous reset in the middle of a divide.
    dividend = 16'd1000;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async rst busy", 64'(busy), 64'd0);
    check("async rst done", 64'(done), 64'd0);
    check("async rst outputs", {31'd0, quotient, remainder, div_by_zero}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) seen++;
      end
      check("no done after abort", 64'(seen), 64'd0);
    end
    do_div(16'd1000, 16'd3, ref_div(16'd1000, 16'd3), "post-reset");

    // Random regression against the arithmetic model.
    have_last = 1'b0;
    hold_en   = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      logic [W-1:0] a, b;
      a = pick_operand();
      b = pick_operand();
      do_div(a, b, ref_div(a, b), "rand");
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    hold_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
